// File: rtl/ocp_pkg.sv
// Shared OCP definitions for the slave memory model and its response FIFO.
//   MCMD_*  : OCP MCmd encodings (IDLE, WR, RD; all other codes are illegal)
//   SRESP_* : OCP SResp encodings (NULL, DVA, ERR)
//   A response record is packed as {resp[1:0], data[DATA_W-1:0]}, resp in the top bits.
package ocp_pkg;

  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  localparam int SRESP_W = 2;

  // Width of a {resp, data} response record for a given data width.
  function automatic int resp_rec_w(input int data_w);
    return data_w + SRESP_W;
  endfunction

endpackage

// File: rtl/ocp_resp_fifo.sv
// Synchronous response FIFO with a registered head.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (ignored when full unless a pop happens in the same cycle)
//   pop        : drop the current head (ignored when empty)
//   head       : registered copy of the oldest entry, all zeros when empty
//   count      : number of stored entries
//   full/empty : status flags
module ocp_resp_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_nx;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    remain;
  logic [WIDTH-1:0] head_nx;
  logic             pop_en;
  logic             push_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign cnt_nx = count + CW'(push_en) - CW'(pop_en);
  assign remain = count - CW'(pop_en);
  assign rd_nx  = rd_ptr + AW'(pop_en);

  // The head register is loaded with whatever will be oldest after this edge;
  // when nothing older survives the pop, that is the entry being pushed now.
  always_comb begin
    head_nx = '0;
    if (cnt_nx != '0) begin
      if (remain == '0) head_nx = push_data;
      else              head_nx = mem[rd_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nx;
      count  <= cnt_nx;
      head   <= head_nx;
    end
  end

endmodule

// File: rtl/ocp_slave_mem.sv
// OCP slave memory model: MEM_DEPTH-word RAM with byte-lane merging, optional
// LFSR-driven command stalls, fixed response latency and a response queue
// honouring MRespAccept backpressure.
//   clk, rst    : clock, synchronous active-high reset
//   mcmd        : OCP MCmd (IDLE/WR/RD, other codes answered with ERR)
//   maddr       : byte address; the word index drops the byte-lane bits
//   mdata       : write data
//   mbyten      : byte enables for write merge and read lane masking
//   scmdaccept  : combinational command accept
//   sresp/sdata : response from the queue head, zero while empty or in reset
//   mrespaccept : master takes the presented response
module ocp_slave_mem
  import ocp_pkg::*;
#(
  parameter int          DATA_W       = 16,
  parameter int          ADDR_W       = 14,
  parameter int          MEM_DEPTH    = 4096,
  parameter int          RESP_LAT     = 1,
  parameter int          RESP_DEPTH   = 4,
  parameter int          WR_RESP      = 0,
  parameter int          STALL_MODE   = 0,
  parameter int          STALL_THRESH = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             mcmd,
  input  logic [ADDR_W-1:0]      maddr,
  input  logic [DATA_W-1:0]      mdata,
  input  logic [DATA_W/8-1:0]    mbyten,
  output logic                   scmdaccept,
  output logic [1:0]             sresp,
  output logic [DATA_W-1:0]      sdata,
  input  logic                   mrespaccept
);

  localparam int BE_W = DATA_W / 8;
  localparam int BSH  = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int WA   = ADDR_W - BSH;
  localparam int MW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int RW   = resp_rec_w(DATA_W);
  localparam int QCW  = $clog2(RESP_DEPTH) + 1;

  logic [DATA_W-1:0] ram [MEM_DEPTH];
  logic [15:0]       lfsr;
  logic [WA-1:0]     word;
  logic [MW-1:0]     ram_idx;
  logic              in_range, is_wr, is_rd, err, posted, needs_resp;
  logic              stall, room, xfer;
  logic [DATA_W-1:0] rd_merge, new_data;
  logic [RW-1:0]     new_rec;
  logic              new_v;
  logic              fifo_push;
  logic [RW-1:0]     fifo_din;
  logic [RW-1:0]     head;
  logic [QCW-1:0]    q_count;
  int                pipe_occ;
  logic              unused_full, unused_empty, unused_addr;

  assign unused_addr = ^maddr;

  assign word     = maddr[ADDR_W-1:BSH];
  assign ram_idx  = word[MW-1:0];
  assign in_range = {{(32-WA){1'b0}}, word} < 32'(MEM_DEPTH);
  assign is_wr    = (mcmd == MCMD_WR);
  assign is_rd    = (mcmd == MCMD_RD);
  assign err      = !(is_wr || is_rd) || !in_range;
  // Only a good write with no write response skips the credit check.
  assign posted     = is_wr && in_range && (WR_RESP == 0);
  assign needs_resp = !posted;

  assign stall = (STALL_MODE == 1) && ({1'b0, lfsr[3:0]} < 5'(STALL_THRESH));
  // Credits cover both queued responses and those still in the latency pipe,
  // so the queue can never overflow.
  assign room  = (int'(q_count) + pipe_occ) < RESP_DEPTH;

  assign scmdaccept = !rst && (mcmd != MCMD_IDLE) && !stall && (room || posted);
  assign xfer       = scmdaccept;

  always_comb begin
    rd_merge = '0;
    for (int b = 0; b < BE_W; b++) begin
      if (mbyten[b]) rd_merge[8*b +: 8] = ram[ram_idx][8*b +: 8];
    end
  end

  assign new_data = (is_rd && !err) ? rd_merge : '0;
  assign new_rec  = {(err ? SRESP_ERR : SRESP_DVA), new_data};
  assign new_v    = xfer && needs_resp;

  always_ff @(posedge clk) begin
    if (xfer && is_wr && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mbyten[b]) ram[ram_idx][8*b +: 8] <= mdata[8*b +: 8];
      end
    end
  end

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  // RESP_LAT-1 register stages ahead of the queue; the queue head register
  // supplies the final cycle of latency.
  if (RESP_LAT > 1) begin : g_pipe
    localparam int PS = RESP_LAT - 1;
    logic [PS-1:0] pv;
    logic [RW-1:0] pd [PS];

    always_ff @(posedge clk) begin
      if (rst) begin
        pv <= '0;
      end else begin
        pv[0] <= new_v;
        for (int k = 1; k < PS; k++) pv[k] <= pv[k-1];
      end
      pd[0] <= new_rec;
      for (int k = 1; k < PS; k++) pd[k] <= pd[k-1];
    end

    always_comb begin
      pipe_occ = 0;
      for (int k = 0; k < PS; k++) pipe_occ += int'(pv[k]);
    end

    assign fifo_push = pv[PS-1];
    assign fifo_din  = pd[PS-1];
  end else begin : g_direct
    assign fifo_push = new_v;
    assign fifo_din  = new_rec;
    assign pipe_occ  = 0;
  end

  ocp_resp_fifo #(
    .WIDTH (RW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (mrespaccept),
    .head      (head),
    .count     (q_count),
    .full      (unused_full),
    .empty     (unused_empty)
  );

  // The head register only clears at the reset edge, so gate it while rst is high.
  assign sresp = rst ? SRESP_NULL : head[RW-1 -: 2];
  assign sdata = rst ? '0 : head[DATA_W-1:0];

endmodule

// File: tb/tb_ocp_slave_mem.sv
module tb_ocp_slave_mem;
  import ocp_pkg::*;

  localparam int          MEM_DEPTH = 64;
  localparam int          RESP_LAT  = 3;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mcmd = MCMD_IDLE;
  logic [13:0] maddr = '0;
  logic [15:0] mdata = '0;
  logic [1:0]  mbyten = '0;
  logic        scmdaccept;
  logic [1:0]  sresp;
  logic [15:0] sdata;
  logic        mrespaccept = 1'b1;

  always #5 clk = ~clk;

  ocp_slave_mem #(
    .DATA_W(16), .ADDR_W(14), .MEM_DEPTH(MEM_DEPTH), .RESP_LAT(RESP_LAT),
    .RESP_DEPTH(4), .WR_RESP(0), .STALL_MODE(1), .STALL_THRESH(8), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .mcmd(mcmd), .maddr(maddr), .mdata(mdata), .mbyten(mbyten),
    .scmdaccept(scmdaccept), .sresp(sresp), .sdata(sdata), .mrespaccept(mrespaccept)
  );

  typedef struct packed {
    logic [2:0]  c;
    logic [13:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [1:0]  r;
    logic [15:0] x;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [15:0] data;
    int          xcyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem_m [MEM_DEPTH];
  logic [15:0] lfsr_m;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          lat_en = 1'b1;
  bit          stall_en = 1'b1;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= rst ? SEED : {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the negedge before the transfer edge; hand=1 uses the vector's
  // own expected response, hand=0 derives it from the memory model.
  task automatic expect_cmd(input vec_t v, input bit hand);
    exp_t e;
    int   w;
    bit   legal;
    w       = int'(v.a[13:1]);
    legal   = ((v.c == MCMD_RD) || (v.c == MCMD_WR)) && (w < MEM_DEPTH);
    e.xcyc  = cyc + 1;
    e.chk_lat = lat_en;
    e.data  = '0;
    e.resp  = SRESP_ERR;
    if (hand) begin
      if (v.r != SRESP_NULL) begin
        e.resp = v.r;
        e.data = v.x;
        sb.push_back(e);
      end
    end else if (!legal) begin
      sb.push_back(e);
    end else if (v.c == MCMD_RD) begin
      e.resp = SRESP_DVA;
      for (int b = 0; b < 2; b++) if (v.be[b]) e.data[8*b +: 8] = mem_m[w][8*b +: 8];
      sb.push_back(e);
    end
    if (legal && v.c == MCMD_WR)
      for (int b = 0; b < 2; b++) if (v.be[b]) mem_m[w][8*b +: 8] = v.d[8*b +: 8];
  endtask

  // Entered at a negedge, returns at the negedge following the transfer.
  task automatic issue(input vec_t v, input bit hand);
    bit done = 1'b0;
    mcmd = v.c; maddr = v.a; mdata = v.d; mbyten = v.be;
    for (int t = 0; t < 64 && !done; t++) begin
      #1;
      if (stall_en) check("stall_vs_lfsr", scmdaccept, lfsr_m[3:0] >= 4'd8);
      if (scmdaccept) begin
        expect_cmd(v, hand);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check("accept_timeout", 0, 1);
    mcmd = MCMD_IDLE;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  // Monitor: checks the head each cycle, pops the scoreboard on accepted responses.
  exp_t        me;
  logic [1:0]  p_resp;
  logic [15:0] p_data;
  bit          p_vis = 1'b0;
  bit          p_acc = 1'b0;
  int          head_cyc = 0;

  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      p_vis = 1'b0;
      p_acc = 1'b0;
    end else begin
      if (p_vis && !p_acc) begin
        check("hold_resp", sresp, p_resp);
        check("hold_data", sdata, p_data);
      end
      if (sresp != SRESP_NULL && (!p_vis || p_acc)) head_cyc = cyc;
      if (sresp == SRESP_NULL) begin
        check("idle_data", sdata, 0);
      end else if (mrespaccept) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", sresp, SRESP_NULL);
        end else begin
          me = sb.pop_front();
          check("resp", sresp, me.resp);
          check("data", sdata, me.data);
          // Visible after edge xfer+RESP_LAT-1, i.e. takeable RESP_LAT cycles after transfer.
          if (me.chk_lat) check("latency", head_cyc - me.xcyc, RESP_LAT - 1);
        end
      end
      p_vis  = (sresp != SRESP_NULL);
      p_acc  = mrespaccept;
      p_resp = sresp;
      p_data = sdata;
    end
  end

  vec_t dir [18];
  vec_t v;
  int   n_acc;
  int   r;

  initial begin
    // Preload word i = 16'h5A00 | i, so untouched words have known values.
    dir = '{
      '{MCMD_WR, 14'h0010, 16'hBEEF, 2'b11, SRESP_NULL, 16'h0000},
      '{MCMD_RD, 14'h0010, 16'h0000, 2'b11, SRESP_DVA,  16'hBEEF},
      '{MCMD_WR, 14'h0020, 16'h1234, 2'b11, SRESP_NULL, 16'h0000},
      '{MCMD_WR, 14'h0020, 16'hAB00, 2'b10, SRESP_NULL, 16'h0000},
      '{MCMD_RD, 14'h0020, 16'h0000, 2'b11, SRESP_DVA,  16'hAB34},
      '{MCMD_RD, 14'h0020, 16'h0000, 2'b01, SRESP_DVA,  16'h0034},
      '{MCMD_RD, 14'h0020, 16'h0000, 2'b10, SRESP_DVA,  16'hAB00},
      '{MCMD_WR, 14'h0022, 16'hFFFF, 2'b00, SRESP_NULL, 16'h0000},
      '{MCMD_RD, 14'h0022, 16'h0000, 2'b11, SRESP_DVA,  16'h5A11},
      '{MCMD_RD, 14'h0080, 16'h0000, 2'b11, SRESP_ERR,  16'h0000},
      '{MCMD_WR, 14'h0080, 16'h7777, 2'b11, SRESP_ERR,  16'h0000},
      '{MCMD_RD, 14'h0000, 16'h0000, 2'b11, SRESP_DVA,  16'h5A00},
      '{MCMD_RD, 14'h007E, 16'h0000, 2'b11, SRESP_DVA,  16'h5A3F},
      '{MCMD_RD, 14'h3FFE, 16'h0000, 2'b11, SRESP_ERR,  16'h0000},
      '{3'b100,  14'h0010, 16'h0000, 2'b11, SRESP_ERR,  16'h0000},
      '{3'b111,  14'h0010, 16'h0000, 2'b11, SRESP_ERR,  16'h0000},
      '{MCMD_WR, 14'h0011, 16'hCAFE, 2'b01, SRESP_NULL, 16'h0000},
      '{MCMD_RD, 14'h0010, 16'h0000, 2'b11, SRESP_DVA,  16'hBEFE}
    };

    // Reset, with a read presented that must not be accepted.
    repeat (2) @(negedge clk);
    mcmd = MCMD_RD; maddr = 14'h0010; mbyten = 2'b11;
    #1;
    check("rst_accept", scmdaccept, 0);
    check("rst_sresp", sresp, SRESP_NULL);
    check("rst_sdata", sdata, 0);
    @(negedge clk);
    rst = 1'b0;
    mcmd = MCMD_IDLE;

    for (int i = 0; i < MEM_DEPTH; i++) begin
      v = '{MCMD_WR, 14'(2 * i), 16'h5A00 | 16'(i), 2'b11, SRESP_NULL, 16'h0000};
      issue(v, 1'b0);
    end

    foreach (dir[i]) issue(dir[i], 1'b1);
    drain();

    // Backpressure: no response is taken, so only RESP_DEPTH reads get in.
    stall_en = 1'b0; lat_en = 1'b0; mrespaccept = 1'b0;
    n_acc = 0;
    for (int t = 0; t < 40; t++) begin
      v = '{MCMD_RD, 14'(32 + 2 * n_acc), 16'h0000, 2'b11, SRESP_NULL, 16'h0000};
      mcmd = v.c; maddr = v.a; mbyten = v.be;
      #1;
      if (scmdaccept) begin
        expect_cmd(v, 1'b0);
        n_acc++;
      end
      @(negedge clk);
    end
    check("bp_accepted", n_acc, 4);
    #1;
    check("bp_blocked", scmdaccept, 0);
    mrespaccept = 1'b1;
    for (int t = 0; t < 60 && n_acc < 6; t++) begin
      v = '{MCMD_RD, 14'(32 + 2 * n_acc), 16'h0000, 2'b11, SRESP_NULL, 16'h0000};
      mcmd = v.c; maddr = v.a; mbyten = v.be;
      #1;
      if (scmdaccept) begin
        expect_cmd(v, 1'b0);
        n_acc++;
      end
      @(negedge clk);
    end
    mcmd = MCMD_IDLE;
    check("bp_total", n_acc, 6);
    drain();
    stall_en = 1'b1; lat_en = 1'b1;

    // Random traffic against the memory model.
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 15));
      v.d  = 16'($urandom());
      v.be = 2'($urandom_range(0, 3));
      v.r  = SRESP_NULL;
      v.x  = '0;
      v.a  = 14'(2 * $urandom_range(0, MEM_DEPTH - 1));
      if (r < 7)       v.c = MCMD_RD;
      else if (r < 14) v.c = MCMD_WR;
      else if (r == 14) v.c = 3'($urandom_range(3, 7));
      else begin
        v.c = ($urandom_range(0, 1) == 0) ? MCMD_RD : MCMD_WR;
        v.a = 14'(128 + 2 * $urandom_range(0, 8000));
      end
      issue(v, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    // Reset with three responses pending.
    stall_en = 1'b0; lat_en = 1'b0; mrespaccept = 1'b0;
    issue('{MCMD_RD, 14'h0010, 16'h0000, 2'b11, SRESP_NULL, 16'h0000}, 1'b0);
    issue('{MCMD_RD, 14'h0020, 16'h0000, 2'b11, SRESP_NULL, 16'h0000}, 1'b0);
    issue('{MCMD_RD, 14'h007E, 16'h0000, 2'b11, SRESP_NULL, 16'h0000}, 1'b0);
    repeat (6) @(negedge clk);
    check("queued_before_rst", sresp, SRESP_DVA);
    rst = 1'b1;
    sb.delete();
    mcmd = MCMD_RD; maddr = 14'h0010; mbyten = 2'b11;
    #1;
    check("midrst_accept", scmdaccept, 0);
    check("midrst_sresp", sresp, SRESP_NULL);
    @(negedge clk);
    rst = 1'b0;
    mcmd = MCMD_IDLE;
    #1;
    check("post_rst_sresp", sresp, SRESP_NULL);
    check("post_rst_sdata", sdata, 0);
    mrespaccept = 1'b1; stall_en = 1'b1; lat_en = 1'b1;
    @(negedge clk);
    issue('{MCMD_RD, 14'h0010, 16'h0000, 2'b11, SRESP_NULL, 16'h0000}, 1'b0);
    issue('{MCMD_RD, 14'h007E, 16'h0000, 2'b11, SRESP_NULL, 16'h0000}, 1'b0);
    issue('{MCMD_RD, 14'h0020, 16'h0000, 2'b01, SRESP_NULL, 16'h0000}, 1'b0);
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
